// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU.
// One-deep response register with valid/ready backpressure.
module alu #(
  parameter int N = 32
) (
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    unique case (op)
      3'b000: result = a & b;
      3'b001: result = a | b;
      3'b010: result = a + b;
      3'b011: err    = 1'b1;
      3'b100: result = a & ~b;
      3'b101: result = a | ~b;
      3'b110: result = a - b;
      3'b111: result = (a < b) ? '1 : '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

module alu_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [2:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [2:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         req1_ready,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_zero,
  output logic         rsp_id,
  output logic         rsp_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state;
  logic         prio;
  logic         can_accept;
  logic         g0;
  logic         g1;
  logic         grant;
  logic [2:0]   alu_op;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [N-1:0] alu_result;
  logic         alu_zero;
  logic         alu_err;

  assign can_accept = rst_n &&
                      (state == EMPTY || rsp_ready);

  // Ready looks only at the other port's valid.
  assign req0_ready = can_accept &&
                      (!prio || !req1_valid);
  assign req1_ready = can_accept &&
                      (prio || !req0_valid);

  assign g0    = req0_ready && req0_valid;
  assign g1    = req1_ready && req1_valid;
  assign grant = g0 || g1;

  assign alu_op = g1 ? req1_op : req0_op;
  assign alu_a  = g1 ? req1_a  : req0_a;
  assign alu_b  = g1 ? req1_b  : req0_b;

  alu #(.N(N)) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result),
    .zero   (alu_zero),
    .err    (alu_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      prio       <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (grant) begin
      state      <= FULL;
      prio       <= g0;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      rsp_id     <= g1;
      rsp_err    <= alu_err;
    end else if (rsp_ready) begin
      state <= EMPTY;
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, scoreboard queue,
// directed contention, backpressure and reset sequences.
module tb_alu_arbiter;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid;
  logic [2:0]   req0_op;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic         req0_ready;
  logic         req1_valid;
  logic [2:0]   req1_op;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic         req1_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_result;
  logic         rsp_zero;
  logic         rsp_id;
  logic         rsp_err;

  alu_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] r;
    logic         z;
    logic         e;
  } vec_t;

  typedef struct {
    logic [N-1:0] r;
    logic         z;
    logic         e;
    logic         id;
  } exp_t;

  exp_t q[$];
  exp_t held;
  vec_t vecs[11];

  int   passed = 0;
  int   total  = 0;
  logic m_full = 1'b0;
  logic m_prio = 1'b0;
  logic last_gid = 1'b0;

  task automatic chk(input string name,
                     input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  function automatic exp_t ref_op(input logic [2:0] op,
                                  input logic [N-1:0] a,
                                  input logic [N-1:0] b,
                                  input logic id);
    exp_t x;
    x.e  = 1'b0;
    x.id = id;
    case (op)
      3'b000:  x.r = a & b;
      3'b001:  x.r = a | b;
      3'b010:  x.r = a + b;
      3'b100:  x.r = a & ~b;
      3'b101:  x.r = a | ~b;
      3'b110:  x.r = a - b;
      3'b111:  x.r = (a < b) ? {N{1'b1}} : {N{1'b0}};
      default: begin x.r = '0; x.e = 1'b1; end
    endcase
    x.z = (x.r == '0);
    return x;
  endfunction

  task automatic tick();
    logic acc, e0, e1, granted;
    exp_t x;
    #1;
    acc = !m_full || rsp_ready;
    e0  = acc && req0_valid && (!req1_valid || !m_prio);
    e1  = acc && req1_valid && (!req0_valid || m_prio);
    if (!acc) begin
      chk("ready0_blocked", {31'b0, req0_ready}, 0);
      chk("ready1_blocked", {31'b0, req1_ready}, 0);
    end else begin
      if (req0_valid) chk("req0_ready", {31'b0, req0_ready}, {31'b0, e0});
      if (req1_valid) chk("req1_ready", {31'b0, req1_ready}, {31'b0, e1});
    end
    granted = e0 || e1;
    if (granted) begin
      last_gid = e1;
      if (e1) q.push_back(ref_op(req1_op, req1_a, req1_b, 1'b1));
      else    q.push_back(ref_op(req0_op, req0_a, req0_b, 1'b0));
      m_full = 1'b1;
      m_prio = e0;
    end else if (rsp_ready) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    if (granted) begin
      if (q.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        x = q.pop_front();
        held = x;
        chk("rsp_valid", {31'b0, rsp_valid}, 1);
        chk("rsp_result", rsp_result, x.r);
        chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, x.z});
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, x.e});
        chk("rsp_id", {31'b0, rsp_id}, {31'b0, x.id});
      end
    end else if (m_full) begin
      chk("hold_valid", {31'b0, rsp_valid}, 1);
      chk("hold_result", rsp_result, held.r);
      chk("hold_zero", {31'b0, rsp_zero}, {31'b0, held.z});
      chk("hold_id", {31'b0, rsp_id}, {31'b0, held.id});
    end else begin
      chk("idle_valid", {31'b0, rsp_valid}, 0);
    end
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0]  = '{3'b010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0};
    vecs[1]  = '{3'b010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0};
    vecs[2]  = '{3'b111, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[3]  = '{3'b011, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1};
    vecs[4]  = '{3'b110, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0};
    vecs[5]  = '{3'b000, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0};
    vecs[6]  = '{3'b001, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0};
    vecs[7]  = '{3'b100, 32'hFF, 32'h0F, 32'hF0, 1'b0, 1'b0};
    vecs[8]  = '{3'b101, 32'h10, 32'hFFFFFFFE, 32'h11, 1'b0, 1'b0};
    vecs[9]  = '{3'b111, 32'd5, 32'd3, 32'd0, 1'b1, 1'b0};
    vecs[10] = '{3'b110, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0};

    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req0_op    = 3'b010;
    req0_a     = 32'd1;
    req0_b     = 32'd2;
    req1_valid = 1'b1;
    req1_op    = 3'b010;
    req1_a     = 32'd3;
    req1_b     = 32'd4;
    rsp_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, rsp_valid}, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_zero", {31'b0, rsp_zero}, 0);
    chk("rst_id", {31'b0, rsp_id}, 0);
    chk("rst_err", {31'b0, rsp_err}, 0);
    chk("rst_ready0", {31'b0, req0_ready}, 0);
    chk("rst_ready1", {31'b0, req1_ready}, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);

    // Vector table, back-to-back through requester 0.
    for (int i = 0; i < 11; i++) begin
      req0_valid = 1'b1;
      req0_op    = vecs[i].op;
      req0_a     = vecs[i].a;
      req0_b     = vecs[i].b;
      rsp_ready  = 1'b1;
      tick();
      chk($sformatf("vec%0d_result", i), rsp_result, vecs[i].r);
      chk($sformatf("vec%0d_zero", i), {31'b0, rsp_zero}, {31'b0, vecs[i].z});
      chk($sformatf("vec%0d_err", i), {31'b0, rsp_err}, {31'b0, vecs[i].e});
    end
    idle();

    // Contention from a fresh reset.
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    q.delete();
    m_full = 1'b0;
    m_prio = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1;
    req0_op    = 3'b010;
    req0_a     = 32'd1;
    req0_b     = 32'd1;
    req1_valid = 1'b1;
    req1_op    = 3'b010;
    req1_a     = 32'd2;
    req1_b     = 32'd2;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr_grant%0d", i), {31'b0, last_gid}, i % 2);
    end
    idle();

    // Backpressure with a zero result held.
    req0_valid = 1'b1;
    req0_op    = 3'b110;
    req0_a     = 32'd3;
    req0_b     = 32'd3;
    tick();
    chk("bp_zero", {31'b0, rsp_zero}, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_op    = 3'b010;
    req1_a     = 32'd10;
    req1_b     = 32'd20;
    rsp_ready  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("bp_hold%0d", i), rsp_result, 0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_gid", {31'b0, last_gid}, 1);
    chk("bp_result", rsp_result, 32'd30);
    idle();

    // Reset with a response held.
    req0_valid = 1'b1;
    req0_op    = 3'b001;
    req0_a     = 32'hA5;
    req0_b     = 32'h0;
    tick();
    chk("mid_a5", rsp_result, 32'hA5);
    req0_valid = 1'b0;
    rsp_ready  = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, rsp_valid}, 0);
    chk("mid_rst_result", rsp_result, 0);
    chk("mid_rst_ready0", {31'b0, req0_ready}, 0);
    q.delete();
    m_full = 1'b0;
    m_prio = 1'b0;
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("mid_no_ghost", {31'b0, rsp_valid}, 0);
    req0_valid = 1'b1;
    req0_op    = 3'b010;
    req0_a     = 32'd4;
    req0_b     = 32'd4;
    req1_valid = 1'b1;
    req1_op    = 3'b000;
    req1_a     = 32'hFF;
    req1_b     = 32'h0F;
    tick();
    chk("mid_first_gid", {31'b0, last_gid}, 0);
    tick();
    chk("mid_second_gid", {31'b0, last_gid}, 1);
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: N, default 32, operand/result width.
REQ-002 The block SHALL have the following ports (one per line: name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_op  in  3  requester 0 ALU control code.
- req0_a, req0_b  in  N  requester 0 operands.
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid, req1_op, req1_a, req1_b, req1_ready  same as requester 0, for requester 1.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  N  registered ALU result.
- rsp_zero  out  1  registered zero flag (result == 0).
- rsp_id  out  1  requester that issued the operation.
- rsp_err  out  1  op code was 3'b011 (undefined).

Function
REQ-003 The block SHALL contain exactly one instance of the codebase ALU (parameter N) shared by both requesters.
REQ-004 Op codes SHALL be as follows:
- 000 AND; 001 OR; 010 ADD.
- 100 A&~B; 101 A|~B; 110 SUB.
- 111 unsigned SLT, giving all-ones if A<B, else 0.
- 011 gives result 0, zero=1, err=1.
REQ-005 ADD/SUB SHALL wrap modulo 2^N, with no carry or overflow output.
REQ-006 The FSM SHALL have two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-007 can_accept = EMPTY or (FULL and rsp_ready).
REQ-008 At most one request SHALL be granted per cycle, only when can_accept=1 and at least one reqX_valid=1.
REQ-009 reqX_ready SHALL be combinational, high only for the granted requester in the grant cycle; it SHALL never depend on reqX_valid of the same port.
REQ-010 Arbitration SHALL be round-robin via a 1-bit priority pointer prio:
- Both valid: grant requester prio.
- One valid: grant it regardless of prio.
REQ-011 After each grant, prio SHALL be set to the non-granted index. prio SHALL be unchanged in cycles with no grant.
REQ-012 Latency SHALL be 1 cycle. The granted operands pass through the ALU combinationally. result, zero, err and id are captured at the grant edge; rsp_valid=1 from the next cycle.
REQ-013 The response SHALL be held stable while rsp_valid=1 and rsp_ready=0. Requests SHALL NOT overwrite it.
REQ-014 Transitions:
- EMPTY + grant -> FULL.
- FULL + rsp_ready + grant -> FULL with the new result (back-to-back, full throughput).
- FULL + rsp_ready + no grant -> EMPTY.
- FULL + !rsp_ready -> FULL, with all reqX_ready=0.
REQ-015 Requesters SHALL keep valid/op/operands stable until ready is seen (protocol assumption). The block SHALL NOT register request inputs.
REQ-016 Requests with valid=0 SHALL be ignored entirely, including their op/operands.

Reset
REQ-017 rst_n=0 SHALL asynchronously force the following, independent of clk:
- state=EMPTY, rsp_valid=0.
- rsp_result=0, rsp_zero=0, rsp_id=0, rsp_err=0.
- prio=0.
REQ-018 While rst_n=0, req0_ready and req1_ready SHALL be 0.
REQ-019 Reset asserted mid-operation SHALL drop any held response. No response for it SHALL appear after release.
REQ-020 The first grant after reset release SHALL occur no earlier than the first rising clk edge with rst_n=1.

Verification
REQ-021 The bench SHALL cover at least these directed scenarios:
- Single op: req0 op=010, a=5, b=7, rsp_ready=1 -> req0_ready=1 for 1 cycle; next cycle rsp_valid=1, result=12, zero=0, id=0, err=0.
- Contention: both valid every cycle, rsp_ready=1, from reset -> grants 0,1,0,1; rsp_id alternates each cycle at full throughput.
- Backpressure: response FULL (SUB a=3, b=3 -> result 0, zero=1), rsp_ready=0 for 4 cycles, req1_valid=1 -> reqX_ready=0 and the response is unchanged for 4 cycles; rsp_ready=1 -> req1 granted the same cycle, and its result appears the next cycle.
- Arithmetic edges:
  - ADD 0xFFFFFFFF+1 -> result 0, zero=1.
  - SLT a=1, b=0xFFFFFFFF -> result 0xFFFFFFFF (unsigned).
  - op=011 -> result 0, err=1.
- Reset mid-flight: rsp_valid=1 with result=0xA5, assert rst_n=0 between clock edges -> rsp_valid and rsp_result=0 immediately; prio=0 after release, so the first contention grant goes to req0.
